// File: rtl/program_loader.sv
// Framed byte-stream loader: length, payload, checksum -> RAM writes.
// Holds the CPU in reset until a frame completes with a matching checksum.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] csum
);

    typedef enum logic [2:0] {
        IDLE, LEN, DATA, CSUM, DONE, ERR
    } state_t;

    localparam logic [ADDR_W:0]   REM_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [DATA_W:0]   LEN_CAP  = (DATA_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              xfer;

    assign in_ready = (state_q == LEN) || (state_q == DATA) ||
                      (state_q == CSUM);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    addr_d  = '0;
                    rem_d   = '0;
                    csum_d  = '0;
                end
            end
            LEN: begin
                if (xfer) begin
                    state_d = DATA;
                    // zero or oversize length loads the whole RAM
                    if (in_data == '0 || {1'b0, in_data} >= LEN_CAP)
                        rem_d = REM_FULL;
                    else
                        rem_d = in_data[ADDR_W:0];
                end
            end
            DATA: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    csum_d    = csum_q + in_data;
                    addr_d    = addr_q + ADDR_ONE;
                    rem_d     = rem_q - REM_ONE;
                    if (rem_q == REM_ONE)
                        state_d = CSUM;
                end
            end
            CSUM: begin
                if (xfer)
                    state_d = (in_data == csum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
        hold_d  = (state_d != DONE);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign error    = error_q;
    assign csum     = csum_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected RAM writes are queued
// as payload is driven and matched against wr_en cycles.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [7:0] csum;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        sb_q[$];
    logic [7:0] pl[16];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_wr = 0;

    program_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error), .csum(csum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_wr++;
            if (sb_q.size() == 0) begin
                chk("spurious_wr", 1, 0);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_addr", int'(wr_addr), int'(e.a));
                chk("wr_data", int'(wr_data), int'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [7:0] lenb, input int n,
                             input logic [7:0] ck, input bit gaps);
        send(lenb);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{a: 4'(i), d: pl[i]});
            send(pl[i]);
            if (gaps) begin
                tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        send(ck);
    endtask

    task automatic load_good();
        pl[0] = 8'h86;
        pl[1] = 8'h47;
        pl[2] = 8'h21;
    endtask

    task automatic chk_status(input string tag, input bit d,
                              input bit e, input bit h,
                              input logic [7:0] c);
        chk({tag, "_done"}, int'(done), int'(d));
        chk({tag, "_error"}, int'(error), int'(e));
        chk({tag, "_hold"}, int'(cpu_hold), int'(h));
        chk({tag, "_csum"}, int'(csum), int'(c));
    endtask

    initial begin
        int w0;
        tick();
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        w0 = n_wr;
        repeat (3) tick();
        chk("idle_ready", int'(in_ready), 0);
        chk("idle_wr_addr", int'(wr_addr), 0);
        chk("idle_wr_data", int'(wr_data), 0);
        chk("idle_nowr", n_wr - w0, 0);
        chk_status("idle", 0, 0, 1, 8'h00);
        in_valid = 1'b0;

        load_good();
        pulse_start();
        chk("len_ready", int'(in_ready), 1);
        w0 = n_wr;
        run_frame(8'h03, 3, 8'hEE, 0);
        chk("good_nwr", n_wr - w0, 3);
        chk_status("good", 1, 0, 0, 8'hEE);
        chk("done_ready", int'(in_ready), 0);

        pulse_start();
        chk("reload_done", int'(done), 0);
        chk("reload_hold", int'(cpu_hold), 1);
        chk("reload_csum", int'(csum), 0);
        run_frame(8'h03, 3, 8'hEF, 0);
        tick();
        chk_status("bad", 0, 1, 1, 8'hEE);
        pulse_start();
        chk("err_clear", int'(error), 0);
        run_frame(8'h03, 3, 8'hEE, 0);
        chk_status("recover", 1, 0, 0, 8'hEE);

        for (int i = 0; i < 16; i++) pl[i] = 8'h10;
        pulse_start();
        w0 = n_wr;
        run_frame(8'h00, 16, 8'h00, 0);
        repeat (2) tick();
        chk("full_nwr", n_wr - w0, 16);
        chk_status("full", 1, 0, 0, 8'h00);

        load_good();
        pulse_start();
        w0 = n_wr;
        run_frame(8'h03, 3, 8'hEE, 1);
        tick();
        chk("gap_nwr", n_wr - w0, 3);
        chk_status("gap", 1, 0, 0, 8'hEE);

        pulse_start();
        send(8'h03);
        sb_q.push_back('{a: 4'd0, d: 8'h86});
        send(8'h86);
        sb_q.push_back('{a: 4'd1, d: 8'h47});
        send(8'h47);
        w0 = n_wr;
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h21;
        tick();
        reset = 1'b0;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk_status("rst", 0, 0, 1, 8'h00);
        repeat (2) tick();
        in_valid = 1'b0;
        chk("rst_nwr", n_wr - w0, 1);
        pulse_start();
        run_frame(8'h03, 3, 8'hEE, 0);
        chk_status("after_rst", 1, 0, 0, 8'hEE);

        repeat (2) tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
